// File: rtl/aes_prng_wide_pkg.sv
// Constants, FSM encoding and parameter sanity checks shared by the wide AES PRNG.
package aes_prng_pkg;

  localparam int unsigned MaxLanes = 8;

  localparam logic [63:0] LfsrTaps64 = 64'hD800_0000_0000_0000;

  localparam logic [63:0] LaneDefaultSeed [0:MaxLanes-1] = '{
    64'h9E37_79B9_7F4A_7C15, 64'hC2B2_AE3D_27D4_EB4F,
    64'h1656_67B1_9E37_79F9, 64'h85EB_CA77_C2B2_AE63,
    64'h27D4_EB2F_1656_67C5, 64'hFF51_AFD7_ED55_8CCD,
    64'hC4CE_B9FE_1A85_EC53, 64'h6A09_E667_F3BC_C909
  };

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StLoad
  } prng_state_e;

  function automatic bit data_width_ok(input int unsigned width);
    return (width > 0) && (width % 64 == 0) && (width / 64 <= MaxLanes);
  endfunction

  function automatic bit entropy_width_ok(input int unsigned width);
    return (width > 0) && (64 % width == 0);
  endfunction

endpackage

// File: rtl/prim_cipher_pkg.sv
// Shared lightweight-cipher primitives: the PRINCE 4-bit S-Box and the PRESENT
// 64-bit bit permutation, plus helpers that apply them to a 64-bit word.
package prim_cipher_pkg;

  localparam logic [15:0][3:0] PRINCE_SBOX4 = {
    4'h4, 4'hD, 4'h5, 4'hE, 4'h0, 4'h8, 4'h7, 4'h6,
    4'h1, 4'h9, 4'hC, 4'hA, 4'h2, 4'h3, 4'hF, 4'hB
  };

  // Bit k moves to position 16*k mod 63; bit 63 stays in place.
  function automatic logic [63:0][5:0] present_perm64_gen();
    logic [63:0][5:0] perm;
    for (int k = 0; k < 64; k++) begin
      perm[k] = (k == 63) ? 6'd63 : 6'((16 * k) % 63);
    end
    return perm;
  endfunction

  localparam logic [63:0][5:0] PRESENT_PERM64 = present_perm64_gen();

  function automatic logic [63:0] sbox4_64bit(input logic [63:0]       state_in,
                                              input logic [15:0][3:0]  sbox4);
    logic [63:0] state_out;
    state_out = '0;
    for (int k = 0; k < 16; k++) begin
      state_out[4*k +: 4] = sbox4[state_in[4*k +: 4]];
    end
    return state_out;
  endfunction

  function automatic logic [63:0] perm_64bit(input logic [63:0]      state_in,
                                             input logic [63:0][5:0] perm);
    logic [63:0] state_out;
    state_out = '0;
    for (int k = 0; k < 64; k++) begin
      state_out[perm[k]] = state_in[k];
    end
    return state_out;
  endfunction

endpackage

// File: rtl/aes_prng_wide_if.sv
// Consumer, reseed and entropy handshakes of the wide PRNG; slave is the PRNG side.
interface aes_prng_wide_if #(
  parameter int unsigned DataWidth    = 128,
  parameter int unsigned EntropyWidth = 32
);
  logic                    data_req_i;
  logic                    data_ack_o;
  logic [DataWidth-1:0]    data_o;
  logic                    reseed_req_i;
  logic                    reseed_ack_o;
  logic                    entropy_req_o;
  logic                    entropy_ack_i;
  logic [EntropyWidth-1:0] entropy_i;
  logic                    seed_err_o;

  modport slave (
    input  data_req_i, reseed_req_i, entropy_ack_i, entropy_i,
    output data_ack_o, data_o, reseed_ack_o, entropy_req_o, seed_err_o
  );

  modport master (
    output data_req_i, reseed_req_i, entropy_ack_i, entropy_i,
    input  data_ack_o, data_o, reseed_ack_o, entropy_req_o, seed_err_o
  );
endinterface

// File: rtl/aes_prng_lane.sv
// One 64-bit Galois-LFSR lane with all-zero seed substitution and
// PRINCE S-Box / PRESENT permutation output scrambling.
module aes_prng_lane
  import aes_prng_pkg::*;
  import prim_cipher_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        seed_en_i,
  input  logic [63:0] seed_i,
  input  logic        step_i,
  input  logic [63:0] default_seed,
  output logic [63:0] data_o
);

  logic [63:0] state_q, state_d;
  logic [63:0] seed_sel;

  // An all-zero LFSR state would lock up, so it is never loaded.
  assign seed_sel = (seed_i == '0) ? default_seed : seed_i;

  // NOTE: every path assigns state_d because of the default first line; no latch.
  always_comb begin
    state_d = state_q;
    if (seed_en_i) begin
      state_d = seed_sel;
    end else if (step_i) begin
      state_d = {1'b0, state_q[63:1]} ^ (state_q[0] ? LfsrTaps64 : 64'h0);
    end
  end

  // NOTE: non-blocking assignment for state so all registers update on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= default_seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign data_o = perm_64bit(sbox4_64bit(state_q, PRINCE_SBOX4), PRESENT_PERM64);

endmodule

// File: rtl/aes_prng_wide.sv
// Wide AES PRNG: parallel LFSR lanes, chunked reseeding over a narrow entropy
// bus, zero-seed rejection and optional grant-count triggered reseeding.
module aes_prng_wide
  import aes_prng_pkg::*;
#(
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned EntropyWidth   = 32,
  parameter int unsigned ReseedInterval = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  aes_prng_wide_if.slave   prng_if
);

  localparam int unsigned NumLanes  = DataWidth / 64;
  localparam int unsigned NumChunks = DataWidth / EntropyWidth;
  localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if (!data_width_ok(DataWidth)) begin : gen_data_width_err
    $error("aes_prng_wide: DataWidth must be a non-zero multiple of 64, at most 512");
  end
  if (!entropy_width_ok(EntropyWidth)) begin : gen_entropy_width_err
    $error("aes_prng_wide: EntropyWidth must divide 64");
  end

  prng_state_e          state_q, state_d;
  logic [ChunkW-1:0]    chunk_q, chunk_d;
  logic [DataWidth-1:0] seed_buf_q, seed_buf_d;
  logic [31:0]          grant_cnt_q, grant_cnt_d;
  logic                 auto_pend_q, auto_pend_d;
  logic                 entropy_req_q, entropy_req_d;

  logic                 grant, auto_set, chunk_in, load;
  logic [NumLanes-1:0]  seed_zero;
  logic [DataWidth-1:0] lane_data;

  assign grant = ~rst_i & (state_q == StIdle) & prng_if.data_req_i
               & ~prng_if.reseed_req_i & ~auto_pend_q;
  // The grant reaching the interval is still served; the reseed follows it.
  assign auto_set = (ReseedInterval != 0) && grant
                 && (grant_cnt_q + 32'd1 == 32'(ReseedInterval));
  assign chunk_in = entropy_req_q & prng_if.entropy_ack_i;
  assign load     = (state_q == StLoad);

  always_comb begin
    state_d       = state_q;
    chunk_d       = chunk_q;
    seed_buf_d    = seed_buf_q;
    grant_cnt_d   = grant_cnt_q;
    auto_pend_d   = auto_pend_q;
    entropy_req_d = entropy_req_q;
    case (state_q)
      StIdle: begin
        if (grant) grant_cnt_d = grant_cnt_q + 32'd1;
        if (auto_set) auto_pend_d = 1'b1;
        if (prng_if.reseed_req_i || auto_pend_q || auto_set) begin
          state_d       = StCollect;
          chunk_d       = '0;
          entropy_req_d = 1'b1;
        end
      end
      StCollect: begin
        if (chunk_in) begin
          for (int c = 0; c < NumChunks; c++) begin
            if (chunk_q == ChunkW'(c)) seed_buf_d[c*EntropyWidth +: EntropyWidth] = prng_if.entropy_i;
          end
          chunk_d = chunk_q + ChunkW'(1);
          if (chunk_q == ChunkW'(NumChunks - 1)) begin
            state_d       = StLoad;
            entropy_req_d = 1'b0;
          end
        end
      end
      StLoad: begin
        auto_pend_d = 1'b0;
        grant_cnt_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      chunk_q       <= '0;
      seed_buf_q    <= '0;
      grant_cnt_q   <= '0;
      auto_pend_q   <= 1'b0;
      entropy_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_q       <= chunk_d;
      seed_buf_q    <= seed_buf_d;
      grant_cnt_q   <= grant_cnt_d;
      auto_pend_q   <= auto_pend_d;
      entropy_req_q <= entropy_req_d;
    end
  end

  for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
    assign seed_zero[i] = ~|seed_buf_q[64*i +: 64];

    aes_prng_lane u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .seed_en_i    (load),
      .seed_i       (seed_buf_q[64*i +: 64]),
      .step_i       (grant),
      .default_seed (LaneDefaultSeed[i]),
      .data_o       (lane_data[64*i +: 64])
    );
  end

  // Handshake outputs are forced low for the whole time reset is held.
  assign prng_if.data_ack_o    = grant;
  assign prng_if.data_o        = lane_data;
  assign prng_if.entropy_req_o = ~rst_i & entropy_req_q;
  assign prng_if.reseed_ack_o  = ~rst_i & load & prng_if.reseed_req_i;
  assign prng_if.seed_err_o    = ~rst_i & load & (|seed_zero);

endmodule

// File: tb/tb_aes_prng_wide.sv
// Directed bench for aes_prng_wide: one instance without and one with automatic
// reseeding, checked against an independent LFSR/scramble reference model.
module tb_aes_prng_wide;
  import aes_prng_pkg::*;

  localparam logic [63:0] Taps = 64'hD800_0000_0000_0000;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] m_lane  [2];
  logic [63:0] ma_lane [2];

  aes_prng_wide_if #(.DataWidth(128), .EntropyWidth(32)) bus  ();
  aes_prng_wide_if #(.DataWidth(128), .EntropyWidth(32)) abus ();

  aes_prng_wide #(.DataWidth(128), .EntropyWidth(32), .ReseedInterval(0)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .prng_if (bus)
  );

  aes_prng_wide #(.DataWidth(128), .EntropyWidth(32), .ReseedInterval(3)) dut_auto (
    .clk_i   (clk),
    .rst_i   (rst),
    .prng_if (abus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
      4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
      4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
      4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] m_scramble(input logic [63:0] s);
    logic [63:0] sb;
    logic [63:0] o;
    for (int n = 0; n < 16; n++) sb[4*n +: 4] = m_sbox(s[4*n +: 4]);
    o = '0;
    for (int k = 0; k < 63; k++) o[(16 * k) % 63] = sb[k];
    o[63] = sb[63];
    return o;
  endfunction

  function automatic logic [63:0] m_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ Taps) : (s >> 1);
  endfunction

  function automatic logic [127:0] m_data(input logic [63:0] l0, input logic [63:0] l1);
    return {m_scramble(l1), m_scramble(l0)};
  endfunction

  task automatic run_reseed(input logic [31:0] c0, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3,
                            output int req_miss, output int grants,
                            output int rack_cnt, output int err_cnt,
                            output logic rack_at_load, output logic err_at_load);
    logic [31:0] ch [4];
    ch[0] = c0; ch[1] = c1; ch[2] = c2; ch[3] = c3;
    req_miss = 0; grants = 0; rack_cnt = 0; err_cnt = 0;
    @(negedge clk);
    bus.reseed_req_i = 1'b1;
    #1;
    grants += int'(bus.data_ack_o); rack_cnt += int'(bus.reseed_ack_o); err_cnt += int'(bus.seed_err_o);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.entropy_ack_i = 1'b1;
      bus.entropy_i     = ch[j];
      #1;
      if (bus.entropy_req_o !== 1'b1) req_miss++;
      grants += int'(bus.data_ack_o); rack_cnt += int'(bus.reseed_ack_o); err_cnt += int'(bus.seed_err_o);
    end
    @(negedge clk);
    bus.entropy_ack_i = 1'b0;
    bus.entropy_i     = '0;
    #1;
    rack_at_load = bus.reseed_ack_o;
    err_at_load  = bus.seed_err_o;
    grants += int'(bus.data_ack_o); rack_cnt += int'(bus.reseed_ack_o); err_cnt += int'(bus.seed_err_o);
    @(negedge clk);
    bus.reseed_req_i = 1'b0;
    #1;
    rack_cnt += int'(bus.reseed_ack_o); err_cnt += int'(bus.seed_err_o);
  endtask

  task automatic test_reset();
    bus.data_req_i = 1'b0; bus.reseed_req_i = 1'b0; bus.entropy_ack_i = 1'b0; bus.entropy_i = '0;
    abus.data_req_i = 1'b0; abus.reseed_req_i = 1'b0; abus.entropy_ack_i = 1'b0; abus.entropy_i = '0;
    rst = 1'b1;
    bus.data_req_i = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.data_ack_o, bus.entropy_req_o, bus.reseed_ack_o, bus.seed_err_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.data_ack_o, bus.entropy_req_o, bus.reseed_ack_o, bus.seed_err_o});
    end
    m_lane[0] = LaneDefaultSeed[0]; m_lane[1] = LaneDefaultSeed[1];
    ma_lane[0] = LaneDefaultSeed[0]; ma_lane[1] = LaneDefaultSeed[1];
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL reset_data_in_reset: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.data_req_i = 1'b0;
    #1;
    checks++;
    if (bus.data_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ack: got %b expected 0", bus.data_ack_o);
    end
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL reset_default_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
    @(negedge clk);
    bus.data_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.data_ack_o !== 1'b1) begin
        errors++;
        $display("FAIL grant_%0d_ack: got %b expected 1", i, bus.data_ack_o);
      end
      checks++;
      if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
        errors++;
        $display("FAIL grant_%0d_data: got %h expected %h", i, bus.data_o, m_data(m_lane[0], m_lane[1]));
      end
      m_lane[0] = m_step(m_lane[0]); m_lane[1] = m_step(m_lane[1]);
      @(negedge clk);
    end
    bus.data_req_i = 1'b0;
    #1;
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL after_3_grants_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
  endtask

  task automatic test_reseed();
    int req_miss, grants, rack_cnt, err_cnt;
    logic rack_at_load, err_at_load;
    // Stray entropy while idle must be ignored.
    @(negedge clk);
    bus.entropy_ack_i = 1'b1;
    bus.entropy_i     = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.entropy_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_entropy_req: got %b expected 0", bus.entropy_req_o);
    end
    @(negedge clk);
    bus.entropy_ack_i = 1'b0;
    bus.entropy_i     = '0;
    run_reseed(32'h1, 32'h2, 32'h3, 32'h4, req_miss, grants, rack_cnt, err_cnt, rack_at_load, err_at_load);
    checks++;
    if (req_miss !== 0) begin
      errors++;
      $display("FAIL reseed_entropy_req: got %0d missing cycles expected 0", req_miss);
    end
    checks++;
    if (rack_at_load !== 1'b1 || rack_cnt !== 1) begin
      errors++;
      $display("FAIL reseed_ack_pulse: got at_load=%b count=%0d expected 1/1", rack_at_load, rack_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL reseed_no_seed_err: got %0d expected 0", err_cnt);
    end
    m_lane[0] = 64'h0000_0002_0000_0001; m_lane[1] = 64'h0000_0004_0000_0003;
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL reseed_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
  endtask

  task automatic test_zero_seed();
    int req_miss, grants, rack_cnt, err_cnt;
    logic rack_at_load, err_at_load;
    run_reseed(32'h0, 32'h0, 32'h5, 32'h6, req_miss, grants, rack_cnt, err_cnt, rack_at_load, err_at_load);
    checks++;
    if (err_at_load !== 1'b1 || err_cnt !== 1) begin
      errors++;
      $display("FAIL zero_seed_err_pulse: got at_load=%b count=%0d expected 1/1", err_at_load, err_cnt);
    end
    checks++;
    if (rack_at_load !== 1'b1) begin
      errors++;
      $display("FAIL zero_seed_ack: got %b expected 1", rack_at_load);
    end
    m_lane[0] = LaneDefaultSeed[0]; m_lane[1] = 64'h0000_0006_0000_0005;
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL zero_seed_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
  endtask

  task automatic test_priority();
    int req_miss, grants, rack_cnt, err_cnt;
    logic rack_at_load, err_at_load;
    bus.data_req_i = 1'b1;
    run_reseed(32'h10, 32'h20, 32'h30, 32'h40, req_miss, grants, rack_cnt, err_cnt, rack_at_load, err_at_load);
    checks++;
    if (grants !== 0) begin
      errors++;
      $display("FAIL priority_no_grant: got %0d grants expected 0", grants);
    end
    m_lane[0] = 64'h0000_0020_0000_0010; m_lane[1] = 64'h0000_0040_0000_0030;
    checks++;
    if (bus.data_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL priority_resume_ack: got %b expected 1", bus.data_ack_o);
    end
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL priority_resume_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
    m_lane[0] = m_step(m_lane[0]); m_lane[1] = m_step(m_lane[1]);
    @(negedge clk);
    bus.data_req_i = 1'b0;
    #1;
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL priority_step_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
  endtask

  task automatic test_auto_reseed();
    int   grants = 0, g_last = -1, e_cyc = -1, dack = 0, rack = 0;
    logic [31:0] ch [4];
    ch[0] = 32'h7; ch[1] = 32'h8; ch[2] = 32'h9; ch[3] = 32'hA;
    @(negedge clk);
    abus.data_req_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (abus.entropy_req_o === 1'b1) begin
        e_cyc = t;
        break;
      end
      if (abus.data_ack_o === 1'b1) begin
        grants++;
        g_last = t;
        checks++;
        if (abus.data_o !== m_data(ma_lane[0], ma_lane[1])) begin
          errors++;
          $display("FAIL auto_grant_%0d_data: got %h expected %h", grants, abus.data_o,
                   m_data(ma_lane[0], ma_lane[1]));
        end
        ma_lane[0] = m_step(ma_lane[0]); ma_lane[1] = m_step(ma_lane[1]);
      end
      @(negedge clk);
    end
    checks++;
    if (e_cyc < 0) begin
      errors++;
      $display("FAIL auto_timeout: entropy_req never rose within 10 cycles, got %0d grants expected 3", grants);
    end
    checks++;
    if (grants !== 3 || e_cyc !== g_last + 1) begin
      errors++;
      $display("FAIL auto_grant_count: got %0d grants, req at cycle %0d after last grant %0d expected 3 and next cycle",
               grants, e_cyc, g_last);
    end
    for (int j = 0; j < 4; j++) begin
      abus.entropy_ack_i = 1'b1;
      abus.entropy_i     = ch[j];
      #1;
      dack += int'(abus.data_ack_o);
      rack += int'(abus.reseed_ack_o);
      @(negedge clk);
    end
    abus.entropy_ack_i = 1'b0;
    abus.entropy_i     = '0;
    #1;
    dack += int'(abus.data_ack_o);
    rack += int'(abus.reseed_ack_o);
    checks++;
    if (rack !== 0 || dack !== 0) begin
      errors++;
      $display("FAIL auto_no_ack: got reseed_ack=%0d data_ack=%0d expected 0/0", rack, dack);
    end
    @(negedge clk);
    #1;
    ma_lane[0] = 64'h0000_0008_0000_0007; ma_lane[1] = 64'h0000_000A_0000_0009;
    checks++;
    if (abus.data_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL auto_resume_ack: got %b expected 1", abus.data_ack_o);
    end
    checks++;
    if (abus.data_o !== m_data(ma_lane[0], ma_lane[1])) begin
      errors++;
      $display("FAIL auto_resume_data: got %h expected %h", abus.data_o, m_data(ma_lane[0], ma_lane[1]));
    end
    @(negedge clk);
    abus.data_req_i = 1'b0;
  endtask

  task automatic test_reset_mid_collect();
    int req_miss, grants, rack_cnt, err_cnt;
    logic rack_at_load, err_at_load;
    @(negedge clk);
    bus.reseed_req_i = 1'b1;
    @(negedge clk);
    bus.entropy_ack_i = 1'b1;
    bus.entropy_i     = 32'h11;
    @(negedge clk);
    bus.entropy_i     = 32'h22;
    @(negedge clk);
    bus.entropy_ack_i = 1'b0;
    bus.entropy_i     = '0;
    bus.reseed_req_i  = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.entropy_req_o !== 1'b0 || bus.reseed_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got req=%b ack=%b expected 0/0", bus.entropy_req_o, bus.reseed_ack_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_lane[0] = LaneDefaultSeed[0]; m_lane[1] = LaneDefaultSeed[1];
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL midreset_default_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
    checks++;
    if (bus.entropy_req_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got entropy_req=%b expected 0", bus.entropy_req_o);
    end
    run_reseed(32'hA, 32'hB, 32'hC, 32'hD, req_miss, grants, rack_cnt, err_cnt, rack_at_load, err_at_load);
    checks++;
    if (req_miss !== 0 || rack_at_load !== 1'b1 || rack_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_full_reseed: got miss=%0d at_load=%b count=%0d expected 0/1/1",
               req_miss, rack_at_load, rack_cnt);
    end
    m_lane[0] = 64'h0000_000B_0000_000A; m_lane[1] = 64'h0000_000D_0000_000C;
    checks++;
    if (bus.data_o !== m_data(m_lane[0], m_lane[1])) begin
      errors++;
      $display("FAIL midreset_reseed_data: got %h expected %h", bus.data_o, m_data(m_lane[0], m_lane[1]));
    end
  endtask

  initial begin
    test_reset();
    test_reseed();
    test_zero_seed();
    test_priority();
    test_auto_reseed();
    test_reset_mid_collect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
